// File: rtl/iomem_dma_master_if.sv
// iomem valid/ready request bus between one initiator and one responder.
// Signal names keep the initiator-side direction suffixes used at the SoC level.
interface iomem_dma_master_if;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [3:0]  m_wstrb_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;

  modport master (
    output m_valid_o, m_wstrb_o, m_addr_o, m_wdata_o,
    input  m_ready_i, m_rdata_i
  );

  modport slave (
    input  m_valid_o, m_wstrb_o, m_addr_o, m_wdata_o,
    output m_ready_i, m_rdata_i
  );
endinterface

// File: rtl/iomem_dma_master.sv
// Word-copy DMA initiator on the iomem bus: each word is one read from the
// source address followed by one write of that data to the destination.
// Requests are registered, held stable until accepted, and always separated
// by at least one idle cycle. A stalled request aborts after TIMEOUT cycles.
module iomem_dma_master #(
  parameter int LEN_BITS = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LEN_BITS-1:0] len_i,
  input  logic                src_inc_i,
  input  logic                dst_inc_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [LEN_BITS-1:0] xfer_cnt_o,
  iomem_dma_master_if.master  bus
);

  // Stall counter only needs to reach TIMEOUT-1; abort fires on that cycle.
  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                src_inc_q, src_inc_d;
  logic                dst_inc_q, dst_inc_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  // Next-state, bus request and transfer bookkeeping.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    valid_d   = valid_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    err_d     = err_q;
    tmo_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          cnt_d = '0;
          if (len_i != '0) begin
            src_d     = src_addr_i & ~32'h3;
            dst_d     = dst_addr_i & ~32'h3;
            len_d     = len_i;
            src_inc_d = src_inc_i;
            dst_inc_d = dst_inc_i;
            // First read is issued straight from the start cycle.
            valid_d   = 1'b1;
            addr_d    = src_addr_i & ~32'h3;
            wstrb_d   = 4'b0000;
            state_d   = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_READ: begin
        if (!valid_q) begin
          // Entered from a write: the idle gap cycle has just elapsed.
          valid_d = 1'b1;
          addr_d  = src_q;
          wstrb_d = 4'b0000;
        end else if (bus.m_ready_i) begin
          wdata_d = bus.m_rdata_i;
          valid_d = 1'b0;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = dst_q;
          wstrb_d = 4'b1111;
        end else if (bus.m_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + LEN_BITS'(1);
          src_d   = src_q + (src_inc_q ? 32'd4 : 32'd0);
          dst_d   = dst_q + (dst_inc_q ? 32'd4 : 32'd0);
          state_d = (cnt_q + LEN_BITS'(1) == len_q) ? ST_DONE : ST_READ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stall watchdog: counts consecutive unaccepted request cycles.
    if (TIMEOUT != 0 && valid_q && !bus.m_ready_i) begin
      if (tmo_q == TMO_LAST) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        state_d = ST_DONE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      wstrb_q   <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      src_inc_q <= src_inc_d;
      dst_inc_q <= dst_inc_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign busy_o        = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign done_o        = (state_q == ST_DONE);
  assign error_o       = err_q;
  assign xfer_cnt_o    = cnt_q;
  assign bus.m_valid_o = valid_q;
  assign bus.m_wstrb_o = wstrb_q;
  assign bus.m_addr_o  = addr_q;
  assign bus.m_wdata_o = wdata_q;

endmodule

// File: tb/tb_iomem_dma_master.sv
// Directed bench for iomem_dma_master: a registered-ready responder with
// configurable wait states and a stall option, plus a bus protocol monitor.
`timescale 1ns/1ps
module tb_iomem_dma_master;
  localparam int LEN_BITS = 8;
  localparam int TIMEOUT  = 15;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                start_i = 1'b0;
  logic [31:0]         src_addr_i = '0;
  logic [31:0]         dst_addr_i = '0;
  logic [LEN_BITS-1:0] len_i = '0;
  logic                src_inc_i = 1'b0;
  logic                dst_inc_i = 1'b0;
  logic                busy_o, done_o, error_o;
  logic [LEN_BITS-1:0] xfer_cnt_o;

  always #5 clk_i = ~clk_i;

  iomem_dma_master_if bus();

  iomem_dma_master #(.LEN_BITS(LEN_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .src_inc_i  (src_inc_i),
    .dst_inc_i  (dst_inc_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .xfer_cnt_o (xfer_cnt_o),
    .bus        (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Responder configuration (written by the stimulus only).
  int          rsp_wait   = 0;
  int          stall_read = -1;
  logic [31:0] rd_data [8];
  logic        rsp_clr    = 1'b0;

  // Responder logs (written by the responder only).
  int          rd_n, wr_n, wait_cnt, valid_cycles;
  logic [31:0] rd_addr [8];
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];

  // Responder: ready is registered, raised after rsp_wait stalled cycles.
  always @(posedge clk_i) begin
    if (rst_i || rsp_clr) begin
      bus.m_ready_i <= 1'b0;
      bus.m_rdata_i <= '0;
      rd_n          <= 0;
      wr_n          <= 0;
      wait_cnt      <= 0;
      valid_cycles  <= 0;
    end else begin
      bus.m_ready_i <= 1'b0;
      if (bus.m_valid_o) valid_cycles <= valid_cycles + 1;
      if (bus.m_valid_o && !bus.m_ready_i &&
          !(bus.m_wstrb_o == 4'h0 && rd_n == stall_read)) begin
        if (wait_cnt < rsp_wait) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          wait_cnt      <= 0;
          bus.m_ready_i <= 1'b1;
          if (bus.m_wstrb_o == 4'h0) begin
            bus.m_rdata_i      <= rd_data[rd_n[2:0]];
            rd_addr[rd_n[2:0]] <= bus.m_addr_o;
            rd_n               <= rd_n + 1;
          end else begin
            wr_addr[wr_n[2:0]] <= bus.m_addr_o;
            wr_data[wr_n[2:0]] <= bus.m_wdata_o;
            wr_n               <= wr_n + 1;
          end
        end
      end
    end
  end

  // Protocol monitor: request stable while pending, valid drops after accept.
  logic        pv = 1'b0, pr = 1'b0;
  logic [3:0]  ps = '0;
  logic [31:0] pa = '0, pd = '0;
  int          prot_checks = 0, prot_viol = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (pv && !pr && bus.m_valid_o) begin
        prot_checks <= prot_checks + 1;
        if (bus.m_addr_o !== pa || bus.m_wdata_o !== pd || bus.m_wstrb_o !== ps) begin
          prot_viol <= prot_viol + 1;
          $display("protocol: pending request changed addr %h->%h data %h->%h", pa, bus.m_addr_o, pd, bus.m_wdata_o);
        end
      end
      if (pv && pr) begin
        prot_checks <= prot_checks + 1;
        if (bus.m_valid_o !== 1'b0) begin
          prot_viol <= prot_viol + 1;
          $display("protocol: valid still high after accepting edge at %0t", $time);
        end
      end
    end
    pv <= bus.m_valid_o;
    pr <= bus.m_ready_i;
    ps <= bus.m_wstrb_o;
    pa <= bus.m_addr_o;
    pd <= bus.m_wdata_o;
  end

  task automatic clear_responder();
    @(negedge clk_i); rsp_clr = 1'b1;
    @(negedge clk_i); rsp_clr = 1'b0;
  endtask

  // Start pulse in cycle 0; returns at the negedge of cycle 1.
  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input logic [7:0] len, input logic si, input logic di);
    @(negedge clk_i);
    src_addr_i = src; dst_addr_i = dst; len_i = len;
    src_inc_i = si; dst_inc_i = di; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Bounded wait for done_o; cyc = cycle index of the pulse, -1 if none.
  task automatic wait_done(input int from_cyc, input int budget, output int cyc);
    cyc = from_cyc;
    while (!done_o && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!done_o) cyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, done_o, error_o, xfer_cnt_o} !== 11'd0) begin
      n_fail++; $display("FAIL reset_status: got %b expected 0", {busy_o, done_o, error_o, xfer_cnt_o});
    end
    n_cmp++;
    if ({bus.m_valid_o, bus.m_wstrb_o} !== 5'd0) begin
      n_fail++; $display("FAIL reset_req: got %b expected 0", {bus.m_valid_o, bus.m_wstrb_o});
    end
    n_cmp++;
    if ({bus.m_addr_o, bus.m_wdata_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {bus.m_addr_o, bus.m_wdata_o});
    end
  endtask

  task automatic test_basic();
    int cyc;
    rsp_wait = 0; stall_read = -1;
    rd_data[0] = 32'hA5A5_0001; rd_data[1] = 32'hA5A5_0002;
    clear_responder();
    start_xfer(32'h0300_1000, 32'h0300_2000, 8'd2, 1'b0, 1'b1);
    n_cmp++;
    if ({busy_o, bus.m_valid_o, bus.m_wstrb_o, bus.m_addr_o} !== {1'b1, 1'b1, 4'h0, 32'h0300_1000}) begin
      n_fail++; $display("FAIL basic_first_read: got busy=%b valid=%b wstrb=%h addr=%h expected 1 1 0 03001000",
                         busy_o, bus.m_valid_o, bus.m_wstrb_o, bus.m_addr_o);
    end
    wait_done(1, 100, cyc);
    n_cmp++;
    if (cyc !== 12) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 12", cyc); end
    n_cmp++;
    if ({busy_o, error_o, xfer_cnt_o} !== {1'b0, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL basic_status: got busy=%b err=%b cnt=%0d expected 0 0 2", busy_o, error_o, xfer_cnt_o);
    end
    n_cmp++;
    if (wr_n !== 2 || wr_addr[0] !== 32'h0300_2000 || wr_data[0] !== 32'hA5A5_0001 ||
        wr_addr[1] !== 32'h0300_2004 || wr_data[1] !== 32'hA5A5_0002) begin
      n_fail++; $display("FAIL basic_writes: got n=%0d %h<=%h %h<=%h expected 2 03002000<=a5a50001 03002004<=a5a50002",
                         wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    n_cmp++;
    if (rd_addr[1] !== 32'h0300_1000) begin
      n_fail++; $display("FAIL basic_fixed_src: got %h expected 03001000", rd_addr[1]);
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done_o); end
  endtask

  task automatic test_wait_states();
    int cyc;
    rsp_wait = 3; stall_read = -1;
    rd_data[0] = 32'h1111_1111; rd_data[1] = 32'h2222_2222;
    clear_responder();
    start_xfer(32'h0300_4000, 32'h0300_5000, 8'd2, 1'b1, 1'b1);
    wait_done(1, 100, cyc);
    n_cmp++;
    if (cyc !== 24) begin n_fail++; $display("FAIL wait_done_cycle: got %0d expected 24", cyc); end
    n_cmp++;
    if (rd_addr[1] !== 32'h0300_4004 || wr_addr[1] !== 32'h0300_5004 || wr_data[1] !== 32'h2222_2222) begin
      n_fail++; $display("FAIL wait_second_word: got rd@%h wr %h<=%h expected 03004004 03005004<=22222222",
                         rd_addr[1], wr_addr[1], wr_data[1]);
    end
    n_cmp++;
    if (prot_viol !== 0) begin n_fail++; $display("FAIL wait_protocol: got %0d violations expected 0", prot_viol); end
  endtask

  task automatic test_len_zero();
    int cyc;
    rsp_wait = 0; stall_read = -1;
    clear_responder();
    start_xfer(32'h0300_1000, 32'h0300_2000, 8'd0, 1'b1, 1'b1);
    wait_done(1, 10, cyc);
    n_cmp++;
    if (cyc !== 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d expected 1", cyc); end
    n_cmp++;
    if ({busy_o, error_o, bus.m_valid_o} !== 3'b000) begin
      n_fail++; $display("FAIL len0_status: got busy/err/valid=%b expected 000", {busy_o, error_o, bus.m_valid_o});
    end
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (valid_cycles !== 0) begin n_fail++; $display("FAIL len0_no_bus: got %0d valid cycles expected 0", valid_cycles); end
  endtask

  task automatic test_timeout();
    int cyc;
    rsp_wait = 0; stall_read = 1;
    rd_data[0] = 32'h0BAD_0001; rd_data[1] = 32'h0BAD_0002;
    clear_responder();
    start_xfer(32'h0300_1000, 32'h0300_3000, 8'd3, 1'b0, 1'b1);
    wait_done(1, 100, cyc);
    n_cmp++;
    if (cyc !== 22) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d expected 22", cyc); end
    n_cmp++;
    if ({bus.m_valid_o, error_o, xfer_cnt_o} !== {1'b0, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL tmo_status: got valid=%b err=%b cnt=%0d expected 0 1 1", bus.m_valid_o, error_o, xfer_cnt_o);
    end
    n_cmp++;
    if (valid_cycles !== 19 || wr_n !== 1) begin
      n_fail++; $display("FAIL tmo_bus_activity: got %0d valid cycles %0d writes expected 19 1", valid_cycles, wr_n);
    end
    @(negedge clk_i);
    n_cmp++;
    if ({done_o, error_o} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_sticky: got done/err=%b expected 01", {done_o, error_o});
    end
    stall_read = -1;
    rd_data[0] = 32'h0600_D001;
    clear_responder();
    start_xfer(32'h0300_1000, 32'h0300_3000, 8'd1, 1'b0, 1'b1);
    n_cmp++;
    if (error_o !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b expected 0", error_o); end
    wait_done(1, 100, cyc);
    n_cmp++;
    if (cyc !== 6 || xfer_cnt_o !== 8'd1 || wr_data[0] !== 32'h0600_D001) begin
      n_fail++; $display("FAIL tmo_recover: got cyc=%0d cnt=%0d data=%h expected 6 1 0600d001", cyc, xfer_cnt_o, wr_data[0]);
    end
  endtask

  task automatic test_wrap_and_ignore();
    int cyc;
    rsp_wait = 0; stall_read = -1;
    rd_data[0] = 32'hDEAD_0001; rd_data[1] = 32'hDEAD_0002;
    clear_responder();
    start_xfer(32'hFFFF_FFFC, 32'h0300_6000, 8'd2, 1'b1, 1'b0);
    repeat (2) @(negedge clk_i);
    src_addr_i = 32'h1234_5678; len_i = 8'd5; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(4, 100, cyc);
    n_cmp++;
    if (cyc !== 12) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d expected 12", cyc); end
    n_cmp++;
    if (rd_addr[0] !== 32'hFFFF_FFFC || rd_addr[1] !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_src_addr: got %h %h expected fffffffc 00000000", rd_addr[0], rd_addr[1]);
    end
    n_cmp++;
    if (wr_addr[1] !== 32'h0300_6000 || wr_data[1] !== 32'hDEAD_0002 || xfer_cnt_o !== 8'd2) begin
      n_fail++; $display("FAIL wrap_fixed_dst: got %h<=%h cnt=%0d expected 03006000<=dead0002 2", wr_addr[1], wr_data[1], xfer_cnt_o);
    end
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (valid_cycles !== 8 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL ignore_start: got %0d valid cycles busy=%b expected 8 0", valid_cycles, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  found = 0;
    rsp_wait = 3; stall_read = -1;
    rd_data[0] = 32'hCAFE_0001;
    clear_responder();
    start_xfer(32'h0300_1000, 32'h0300_7000, 8'd2, 1'b0, 1'b1);
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.m_valid_o && bus.m_wstrb_o == 4'hF) found = 1;
      else @(negedge clk_i);
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL rstmid_write_seen: got none expected write request"); end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, done_o, error_o, xfer_cnt_o, bus.m_valid_o, bus.m_wstrb_o} !== 16'd0 ||
        {bus.m_addr_o, bus.m_wdata_o} !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got status=%b addr=%h data=%h expected all 0",
                         {busy_o, done_o, error_o, xfer_cnt_o, bus.m_valid_o, bus.m_wstrb_o}, bus.m_addr_o, bus.m_wdata_o);
    end
    rst_i = 1'b0;
    rsp_wait = 0;
    rd_data[0] = 32'h5EED_0001;
    clear_responder();
    start_xfer(32'h0300_1000, 32'h0300_8000, 8'd1, 1'b0, 1'b1);
    wait_done(1, 100, cyc);
    n_cmp++;
    if (cyc !== 6 || wr_addr[0] !== 32'h0300_8000 || wr_data[0] !== 32'h5EED_0001) begin
      n_fail++; $display("FAIL rstmid_fresh: got cyc=%0d %h<=%h expected 6 03008000<=5eed0001", cyc, wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (prot_viol !== 0 || prot_checks == 0) begin
      n_fail++; $display("FAIL protocol_total: got %0d violations in %0d checks expected 0 in >0", prot_viol, prot_checks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_len_zero();
    test_timeout();
    test_wrap_and_ignore();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
